// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, in-order response queue, decode handshake.
// Optional FETCH_BYPASS_EN lets a response reach decode in the same cycle when the queue is empty.
module riscv_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   tag_pc [DEPTH];
    logic [AW-1:0] q_rd, q_wr, tag_rd, tag_wr;
    logic [CW-1:0] count, inflight, drop;
    logic [CW:0]   credit_used;
    logic          q_nonempty;
    logic          req_fire;
    logic          rsp_keep;
    logic          push;
    logic          pop;

    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign q_nonempty     = (count != '0);
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A response survives only if it is not owed to a previous redirect.
    assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid && !reset;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = rsp_keep && !q_nonempty;
    assign instr_valid = (q_nonempty && !redirect_valid) || bypass;
    assign instr_data  = q_nonempty ? q_data[q_rd] : (bypass ? imem_rsp_data : 32'h0);
    assign instr_pc    = q_nonempty ? q_pc[q_rd]   : (bypass ? tag_pc[tag_rd] : 32'h0);
    assign push        = rsp_keep && !(bypass && instr_ready);
    assign pop         = q_nonempty && instr_valid && instr_ready;
`else
    assign instr_valid = q_nonempty && !redirect_valid;
    assign instr_data  = q_nonempty ? q_data[q_rd] : 32'h0;
    assign instr_pc    = q_nonempty ? q_pc[q_rd]   : 32'h0;
    assign push        = rsp_keep;
    assign pop         = instr_valid && instr_ready;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            q_rd     <= '0;
            q_wr     <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (req_fire)
                tag_wr <= tag_wr + 1'b1;
            if (imem_rsp_valid)
                tag_rd <= tag_rd + 1'b1;

            if (redirect_valid) begin
                // Every request still outstanding after this cycle must be discarded on return.
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                drop     <= inflight - CW'(imem_rsp_valid);
                q_rd     <= '0;
                q_wr     <= '0;
                count    <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && (drop != '0))
                    drop <= drop - 1'b1;
                if (push)
                    q_wr <= q_wr + 1'b1;
                if (pop)
                    q_rd <= q_rd + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays carry data only; validity is tracked by the pointers and counters above.
    always_ff @(posedge clk) begin
        if (req_fire)
            tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            q_data[q_wr] <= imem_rsp_data;
            q_pc[q_wr]   <= tag_pc[tag_rd];
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed table-driven bench for riscv_fetch_unit with a fixed-latency in-order memory model.
module tb_riscv_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    riscv_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_first;
        int          lat;
        bit          rq_rdy;
        bit          in_rdy;
        bit          redir;
        logic [31:0] redir_pc;
        bit          e_rv;
        logic [31:0] e_ra;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t  tbl[$];
    pend_t pend[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    lat = 1;
    int    row = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic vec_t mk(input bit rf, input int l, input bit rq, input bit ir,
                                input bit rd, input logic [31:0] rpc, input bit erv,
                                input logic [31:0] era, input bit eiv, input logic [31:0] epc);
        vec_t v;
        v.rst_first = rf;  v.lat = l;     v.rq_rdy = rq;  v.in_rdy = ir;
        v.redir = rd;      v.redir_pc = rpc;
        v.e_rv = erv;      v.e_ra = era;  v.e_iv = eiv;   v.e_pc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d cyc=%0d actual=%h required=%h", name, row, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input int l);
        reset = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        pend.delete();
        lat = l;
        @(negedge clk);
        check("reset_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("reset_req_addr", imem_req_addr, 32'h0);
        check("reset_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("reset_instr_pc", instr_pc, 32'h0);
        check("reset_instr_data", instr_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic do_cycle(input vec_t v);
        if (v.rst_first)
            do_reset(v.lat);
        imem_req_ready = v.rq_rdy;
        instr_ready    = v.in_rdy;
        redirect_valid = v.redir;
        redirect_pc    = v.redir_pc;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        check("req_valid", {31'h0, imem_req_valid}, {31'h0, v.e_rv});
        check("req_addr", imem_req_addr, v.e_ra);
        check("instr_valid", {31'h0, instr_valid}, {31'h0, v.e_iv});
        if (v.e_iv) begin
            check("instr_pc", instr_pc, v.e_pc);
            check("instr_data", instr_data, mem(v.e_pc));
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_t p;
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
`ifndef FETCH_BYPASS_EN
        // Streaming, latency 1, decode always ready.
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 1, 32'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h04, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h08, 1, 32'h00));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h04));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h10, 1, 32'h08));
        // Decode stalled: credit cap of 4, then one pop frees one request.
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 32'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h04, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h0C, 1, 32'h00));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h10, 1, 32'h00));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h10, 1, 32'h00));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h10, 1, 32'h00));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h10, 1, 32'h04));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h14, 1, 32'h04));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h14, 1, 32'h04));
        // Latency 3, redirect with two requests in flight (low bits of target ignored).
        tbl.push_back(mk(1, 3, 1, 1, 0, 0, 1, 32'h000, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h004, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 1, 32'h103, 0, 32'h008, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h100, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h104, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h108, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h10C, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 0, 32'h110, 1, 32'h100));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h110, 1, 32'h104));
        tbl.push_back(mk(0, 3, 1, 1, 0, 0, 1, 32'h114, 1, 32'h108));
        // Latency 2, redirect coincides with a response and a non-empty queue.
        tbl.push_back(mk(1, 2, 1, 1, 0, 0, 1, 32'h00, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h04, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h08, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 1, 32'h40, 0, 32'h0C, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h40, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h44, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h48, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h4C, 1, 32'h40));
        // Address wrap past 0xFFFF_FFFC with imem_req_ready toggling.
        tbl.push_back(mk(1, 1, 1, 1, 1, 32'hFFFF_FFF6, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFF4, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF4));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h0000_0004, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000));
`else
        // Bypass: empty queue forwards the response in the same cycle.
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 1, 32'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h04, 1, 32'h00));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h08, 1, 32'h04));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h04));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            row = i;
            do_cycle(tbl[i]);
        end

        // Reset asserted mid-cycle while the unit is busy: outputs clear without a clock edge.
        row = -1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("async_req_addr", imem_req_addr, 32'h0);
        check("async_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("async_instr_pc", instr_pc, 32'h0);
        check("async_instr_data", instr_data, 32'h0);
        @(negedge clk);
        do_cycle(mk(1, 1, 1, 1, 0, 0, 1, 32'h00, 0, 0));
        do_cycle(mk(0, 1, 1, 1, 0, 0, 1, 32'h04, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Parametrised instruction-fetch front end for the pipelined RISC-V core, replacing the single-cycle combinational instruction port. Issues sequential instruction-memory requests over a valid/ready channel tolerating any response latency ≥1 cycle, buffers returned instructions in a DEPTH-entry FIFO, and delivers {instruction, PC} pairs to the decode stage under a valid/ready handshake. Redirects (taken branch or jump resolved in Execute) flush the queue and discard every in-flight response.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; also the cap on queued + in-flight requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  input  1  sole clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  PCSrcE-equivalent; flush and refetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- instr_valid  output  1  decode-side data valid.
- instr_ready  input  1  decode accepts (driven as !StallD).
- instr_data  output  32  instruction word.
- instr_pc  output  32  address of instr_data.

## Operation
- State: fetch_pc (32), FIFO of {data, pc} (DEPTH entries), inflight counter (0..DEPTH), drop counter (0..DEPTH), pc-tag FIFO for in-flight requests (DEPTH entries).
- Request issue: imem_req_valid = !reset && !redirect_valid && (count + inflight < DEPTH). imem_req_addr = fetch_pc. On req fire: fetch_pc += 4 (mod 2^32 wrap), inflight++, push fetch_pc to tag FIFO.
- Response: each imem_rsp_valid decrements inflight and pops the tag FIFO. If drop > 0: data discarded, drop--. Otherwise {imem_rsp_data, tag} pushed to FIFO (space guaranteed by the credit rule; overflow impossible by construction).
- Decode side: instr_valid = (count > 0) && !redirect_valid; head presented on instr_data/instr_pc; pop when instr_valid && instr_ready.
- Redirect (redirect_valid=1): FIFO cleared; fetch_pc ← {redirect_pc[31:2], 2'b00}; drop ← inflight remaining after this cycle's response (inflight − rsp_valid); pop and request suppressed this cycle. Consecutive redirects: the last one wins; drop accumulates correctly because inflight never increments during redirect.
- Simultaneous push and pop on the FIFO: both apply; count unchanged. Pop when empty impossible (instr_valid=0).
- Full: count + inflight = DEPTH holds request low; instr_valid stays high.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, instr_valid 0, instr_data 0, instr_pc 0, all counters 0, FIFO empty.
- First request: first rising edge after reset deasserts, address RESET_PC.
- Fetch-to-decode latency (no bypass): response cycle N → instr_valid at cycle N+1.
- Redirect-to-request: first request to redirect_pc in cycle R+1; first valid instruction at earliest R+1+mem latency+1.
- Sustained throughput: 1 instruction/cycle when memory latency ≤ DEPTH−1 and decode never stalls.
- Reset mid-operation: all state cleared asynchronously; outstanding memory responses after reset release are not the unit's responsibility (memory is reset by the same signal).

## Configuration
- FETCH_BYPASS_EN defined: when FIFO is empty, drop = 0, no redirect, and imem_rsp_valid=1, the response drives instr_valid/instr_data/instr_pc combinationally in the same cycle; if instr_ready=1 it is consumed and not written to the FIFO, else it is pushed. Fetch-to-decode latency 0.
- Not defined: every response goes through the FIFO; latency exactly 1 cycle; no combinational path from imem_rsp_* to instr_*.

## Test plan
- Reset release, memory 1-cycle latency, decode always ready → requests 0x0,0x4,0x8,… on consecutive cycles; instr_pc 0x0 appears 2 cycles after first request, then one instruction per cycle.
- DEPTH=4, instr_ready held 0 → exactly 4 requests accepted, imem_req_valid stays 0; releasing instr_ready for 1 cycle → one new request next cycle.
- Memory latency 3, redirect to 0x100 with 2 requests in flight → both responses dropped, next request addr 0x100, first instr_pc delivered 0x100.
- Redirect on the same cycle as a response and a decode handshake → response dropped, no pop, drop = inflight−1, FIFO empty next cycle.
- imem_req_ready toggling randomly, fetch_pc crossing 0xFFFF_FFFC → next address 0x0000_0000, order preserved.
- FETCH_BYPASS_EN defined, empty FIFO, response with instr_ready=1 → instr_valid same cycle, FIFO count stays 0.
